// File: rtl/act_pkg.sv
// act_pkg: shared fp32 types, defaults and the ReLU helper for the activation vector packer.
package act_pkg;
  localparam int N_ACT_DEF = 30;
  localparam int FP_W = 32;
  typedef logic [FP_W-1:0] fp32_t;
  localparam fp32_t FP_ZERO = 32'h0;
  function automatic fp32_t relu_fp32(input fp32_t x);
    return x[FP_W-1] ? FP_ZERO : x;
  endfunction
endpackage

// File: rtl/act_bank.sv
// act_bank: one N x W activation register bank; a write can also clear every word above its index.
module act_bank #(
  parameter int N = 30,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [$clog2(N)-1:0] i_idx,
  input  logic [W-1:0]         i_data,
  input  logic                 i_zero_fill,
  output logic [N*W-1:0]       o_vec
);
  localparam int IW = $clog2(N);
  logic [N-1:0][W-1:0] r_mem;
  assign o_vec = r_mem;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mem <= '0;
    else if (i_we)
      for (int i = 0; i < N; i++)
        if (IW'(i) == i_idx) r_mem[i] <= i_data;
        else if (i_zero_fill && IW'(i) > i_idx) r_mem[i] <= '0;
endmodule

// File: rtl/act_vector_packer.sv
// act_vector_packer: packs a serial fp32 stream into ping-pong N_ACT-word vectors.
// Define RELU_EN to clamp negative words (sign bit set) to zero at capture.
module act_vector_packer #(
  parameter int N_ACT = act_pkg::N_ACT_DEF,
  parameter int FP_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [FP_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [N_ACT*FP_W-1:0] out_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  short_frame
);
  import act_pkg::*;
  localparam int IW = $clog2(N_ACT);
  logic [1:0] r_full;
  logic r_wr_sel, r_rd_sel, r_short;
  logic [IW-1:0] r_wr_idx;
  logic w_acc, w_end, w_close, w_drain;
  logic [1:0] w_set, w_clr;
  logic [FP_W-1:0] w_data;
  logic [N_ACT*FP_W-1:0] w_vec [2];
  assign in_ready = !r_full[r_wr_sel];
  assign out_valid = r_full[r_rd_sel];
  assign out_vec = w_vec[r_rd_sel];
  assign short_frame = r_short;
  assign w_acc = in_valid && in_ready;
  assign w_end = r_wr_idx == IW'(N_ACT - 1);
  assign w_close = w_acc && (w_end || in_last);
  assign w_drain = out_valid && out_ready;
  assign w_set = {w_close && r_wr_sel, w_close && !r_wr_sel};
  assign w_clr = {w_drain && r_rd_sel, w_drain && !r_rd_sel};
`ifdef RELU_EN
  assign w_data = relu_fp32(in_data);
`else
  assign w_data = in_data;
`endif
  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(.N(N_ACT), .W(FP_W)) u_bank (
      .clk(clk),
      .rst(rst),
      .i_we(w_acc && (r_wr_sel == 1'(b))),
      .i_idx(r_wr_idx),
      .i_data(w_data),
      .i_zero_fill(in_last && !w_end),
      .o_vec(w_vec[b])
    );
  end
  // A closing bank and a draining bank are always different, so set and clear never collide.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_full <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_idx <= '0;
      r_short <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      r_wr_sel <= r_wr_sel ^ w_close;
      r_rd_sel <= r_rd_sel ^ w_drain;
      r_wr_idx <= w_close ? '0 : w_acc ? r_wr_idx + 1'b1 : r_wr_idx;
      r_short <= r_short | (w_acc && in_last && !w_end);
    end
endmodule

// File: tb/tb_act_vector_packer.sv
// tb_act_vector_packer: scoreboard bench; a queue model of held vectors predicts every handshake and vector.
module tb_act_vector_packer;
  localparam int N = 30;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, short_frame;
  logic [N*W-1:0] out_vec;
  act_vector_packer #(.N_ACT(N), .FP_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_vec(out_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .short_frame(short_frame)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [N*W-1:0] sb [$];
  logic [W-1:0] cur [$];
  bit exp_short = 1'b0;
  bit acc_pending = 1'b0;
  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void chk_vec(string name, logic [N*W-1:0] act, logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 0; i < N; i++)
        if (act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s word %0d: got %h expected %h at %0t", name, i, act[i*W +: W], exp[i*W +: W], $time);
          break;
        end
    end
  endfunction
  function automatic logic [W-1:0] model_word(logic [W-1:0] d);
`ifdef RELU_EN
    return d[W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction
  // Monitor: check DUT against the model, then advance the model by what the next edge will do.
  always @(negedge clk) begin
    bit acc, drain;
    logic [N*W-1:0] v;
    if (rst) begin
      acc_pending = 1'b0;
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_short", W'(short_frame), W'(0));
    end else begin
      chk("in_ready", W'(in_ready), W'(sb.size() < 2));
      chk("out_valid", W'(out_valid), W'(sb.size() > 0));
      chk("short_frame", W'(short_frame), W'(exp_short));
      if (sb.size() > 0 && out_valid) chk_vec("out_vec", out_vec, sb[0]);
      acc = in_valid && sb.size() < 2;
      drain = out_ready && sb.size() > 0;
      acc_pending = acc;
      if (drain) void'(sb.pop_front());
      if (acc) begin
        cur.push_back(model_word(in_data));
        if (cur.size() == N || in_last) begin
          v = '0;
          if (cur.size() < N) exp_short = 1'b1;
          foreach (cur[i]) v[i*W +: W] = cur[i];
          sb.push_back(v);
          cur.delete();
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_pending && n < 200);
    if (!acc_pending) begin
      failures++;
      $display("FAIL send_timeout: word %h not accepted within %0d cycles", d, n);
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    int n;
    idle(3);
    chk_vec("reset_out_vec", out_vec, '0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(32'h3F800000 + W'(i), 1'b0);
    idle(4);
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(32'h41000000 + W'(i), 1'b0);
    idle(4);
    chk("bp_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(4);
    for (int i = 0; i < 5; i++) send(32'h40000000, i == 4);
    idle(3);
    send(32'hBF800000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h3F000000, 1'b1);
    idle(3);
    repeat (1500) begin
      @(posedge clk);
      #1;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom;
      in_last = $urandom_range(0, 11) == 0;
      out_ready = $urandom_range(0, 2) != 0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    idle(10);
    send(32'h3F000001, 1'b1);
    idle(4);
    for (int i = 0; i < 12; i++) send(32'h3E000000 + W'(i), 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    cur.delete();
    exp_short = 1'b0;
    #1;
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_short", W'(short_frame), W'(0));
    chk_vec("mid_rst_out_vec", out_vec, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(32'h42000000 + W'(i), 1'b0);
    idle(3);
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("final_pending", W'(sb.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
